// File: rtl/srt_div_seq.sv
// ---------------------------------------------------------------------------
// srt_div_seq -- sequential radix-2 SRT divider (digit set {-1,+1}).
//
// One non-restoring iteration per clock: W iterations, one correction cycle
// and one DONE cycle. Divide-by-zero skips the iterations and reports
// DZ=1, Q=all ones, R=dividend. One operation may be in flight at a time.
//
// Optional feature macro: SRTDIV_SIGNED_EN
//   When defined, the module gains a SIGNED input, which is captured with
//   START. SIGNED=1 selects two's-complement operands with truncation toward
//   zero. When the macro is undefined, the divider is unsigned only.
//
// Parameters
//   W      operand/result width (>= 4)
//   CNT_W  iteration counter width, derived from W
//
// Ports
//   CLK    in   clock, all state updates on the rising edge
//   RST_N  in   synchronous reset, active-low
//   START  in   request, sampled only while idle
//   SIGNED in   (SRTDIV_SIGNED_EN only) signed operation select
//   DVD    in   dividend, captured on accepted START
//   DSR    in   divisor, captured on accepted START
//   BUSY   out  high from the cycle after accept through the DONE cycle
//   DONE   out  one-cycle result-valid pulse
//   DZ     out  divide-by-zero flag, held until the next result
//   Q      out  quotient, held until the next result
//   R      out  remainder, held until the next result
// ---------------------------------------------------------------------------
module srt_div_seq #(
  parameter int W     = 32,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
`ifdef SRTDIV_SIGNED_EN
  input  logic         SIGNED,
`endif
  input  logic [W-1:0] DVD,
  input  logic [W-1:0] DSR,
  output logic         BUSY,
  output logic         DONE,
  output logic         DZ,
  output logic [W-1:0] Q,
  output logic [W-1:0] R
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
`ifdef SRTDIV_SIGNED_EN
  localparam logic [W-1:0]     ONE_W    = W'(1);
`endif

  state_t           state_r;
  state_t           next_state_s;

  // Datapath: partial remainder (W+1 bits, signed), quotient shift register,
  // divisor magnitude, iteration counter and divide-by-zero marker.
  logic [W:0]       p_r;
  logic [W-1:0]     q_r;
  logic [W-1:0]     d_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dz_r;
`ifdef SRTDIV_SIGNED_EN
  logic             neg_q_r;
  logic             neg_r_r;
  logic             dvd_neg_s;
  logic             dsr_neg_s;
`endif

  logic             dsr_zero_s;
  logic             last_iter_s;
  logic [W-1:0]     dvd_mag_s;
  logic [W-1:0]     dsr_mag_s;
  logic [W:0]       p_sh_s;
  logic [W:0]       p_nxt_s;
  logic [W-1:0]     q_nxt_s;
  logic [W-1:0]     r_mag_s;
  logic [W-1:0]     q_res_s;
  logic [W-1:0]     r_res_s;
  logic             busy_s;
  logic             done_s;

  assign dsr_zero_s  = (DSR == {W{1'b0}});
  assign last_iter_s = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. Divide-by-zero goes through FIX so that its result is
  // written on the same kind of edge as a normal result.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          if (dsr_zero_s) begin
            next_state_s = S_FIX;
          end else begin
            next_state_s = S_ITER;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ITER: begin
        if (last_iter_s) begin
          next_state_s = S_FIX;
        end else begin
          next_state_s = S_ITER;
        end
      end
      S_FIX:   next_state_s = S_DONE;
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output decode, taken from the next state so BUSY/DONE leave a register.
  always_comb begin
    busy_s = (next_state_s != S_IDLE);
    done_s = (next_state_s == S_DONE);
  end

  // Operand magnitudes presented at accept time.
  always_comb begin
`ifdef SRTDIV_SIGNED_EN
    dvd_neg_s = SIGNED & DVD[W-1];
    dsr_neg_s = SIGNED & DSR[W-1];
    if (dvd_neg_s) begin
      dvd_mag_s = ~DVD + ONE_W;
    end else begin
      dvd_mag_s = DVD;
    end
    if (dsr_neg_s) begin
      dsr_mag_s = ~DSR + ONE_W;
    end else begin
      dsr_mag_s = DSR;
    end
`else
    dvd_mag_s = DVD;
    dsr_mag_s = DSR;
`endif
  end

  // One SRT step. The shifted remainder may wrap in W+1 bits, but the
  // add/subtract result always lies in [-D, D), so the modular sum is exact.
  // The digit decision uses the sign of the remainder before the shift.
  always_comb begin
    p_sh_s = {p_r[W-1:0], q_r[W-1]};
    if (p_r[W]) begin
      p_nxt_s = p_sh_s + {1'b0, d_r};
    end else begin
      p_nxt_s = p_sh_s - {1'b0, d_r};
    end
    q_nxt_s = {q_r[W-2:0], ~p_nxt_s[W]};
  end

  // Final correction: restore a negative remainder, then apply signs.
  always_comb begin
    if (p_r[W]) begin
      r_mag_s = p_r[W-1:0] + d_r;
    end else begin
      r_mag_s = p_r[W-1:0];
    end
    if (dz_r) begin
      // In the divide-by-zero case q_r holds the raw dividend.
      q_res_s = {W{1'b1}};
      r_res_s = q_r;
    end else begin
`ifdef SRTDIV_SIGNED_EN
      if (neg_q_r) begin
        q_res_s = ~q_r + ONE_W;
      end else begin
        q_res_s = q_r;
      end
      if (neg_r_r) begin
        r_res_s = ~r_mag_s + ONE_W;
      end else begin
        r_res_s = r_mag_s;
      end
`else
      q_res_s = q_r;
      r_res_s = r_mag_s;
`endif
    end
  end

  // Datapath registers: capture on accept, iterate in ITER, hold otherwise.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      p_r     <= {(W+1){1'b0}};
      q_r     <= {W{1'b0}};
      d_r     <= {W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      dz_r    <= 1'b0;
`ifdef SRTDIV_SIGNED_EN
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (START) begin
            p_r     <= {(W+1){1'b0}};
            q_r     <= dsr_zero_s ? DVD : dvd_mag_s;
            d_r     <= dsr_mag_s;
            cnt_r   <= {CNT_W{1'b0}};
            dz_r    <= dsr_zero_s;
`ifdef SRTDIV_SIGNED_EN
            neg_q_r <= dvd_neg_s ^ dsr_neg_s;
            neg_r_r <= dvd_neg_s;
`endif
          end else begin
            p_r <= p_r;
          end
        end
        S_ITER: begin
          p_r   <= p_nxt_s;
          q_r   <= q_nxt_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        default: begin
          p_r <= p_r;
        end
      endcase
    end
  end

  // Registered outputs. Results are written only when leaving FIX.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BUSY <= 1'b0;
      DONE <= 1'b0;
      DZ   <= 1'b0;
      Q    <= {W{1'b0}};
      R    <= {W{1'b0}};
    end else begin
      BUSY <= busy_s;
      DONE <= done_s;
      if (state_r == S_FIX) begin
        DZ <= dz_r;
        Q  <= q_res_s;
        R  <= r_res_s;
      end else begin
        DZ <= DZ;
      end
    end
  end

endmodule
